// File: rtl/pid_controller_mc.sv
// pid_controller_mc
// -----------------------------------------------------------------------------
// Multi-channel, time-multiplexed PID controller. A single shared signed
// multiplier serves NUM_CH independent loops. A one-cycle `sample` strobe
// starts a sweep that visits every channel in five states:
//   ERR -> MP -> MI -> MD -> OUT
// Each channel keeps three pieces of state: its integrator, its previous
// error, and the direction in which it last saturated.
//
// Ports
//   clk, reset_n        : clock and asynchronous active-low reset
//   en                  : 0 = synchronous clear of all loop state and outputs
//   sample              : one-cycle strobe that starts a sweep (accepted in IDLE)
//   k_p, k_i, k_d       : per-channel unsigned Q(INT.FRAC) gains; channel k is slice k
//   setpoint, feedback  : per-channel unsigned process values; channel k is slice k
//   iwin                : integration window; the loop integrates only when |e| <= iwin
//   busy                : a sweep is in progress
//   out_valid           : one-cycle strobe; out_ch, control_out, error_out and sat
//                         are valid in this cycle
//   out_ch              : channel index of the current result
//   control_out         : clamped control value (integer part)
//   error_out           : error used for this result
//   sat                 : control_out was clamped
//   overrun             : sticky; `sample` arrived while busy
// -----------------------------------------------------------------------------
module pid_controller_mc #(
  parameter  int NUM_CH         = 2,
  parameter  int PID_INT_WIDTH  = 8,
  parameter  int PID_FRAC_WIDTH = 8,
  parameter  int PV_WIDTH       = 9,
  parameter  int CONTROL_WIDTH  = 16,
  parameter  int ACC_WIDTH      = 32,
  localparam int GW             = PID_INT_WIDTH + PID_FRAC_WIDTH,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            en,
  input  logic                            sample,
  input  logic [NUM_CH*GW-1:0]            k_p,
  input  logic [NUM_CH*GW-1:0]            k_i,
  input  logic [NUM_CH*GW-1:0]            k_d,
  input  logic [NUM_CH*PV_WIDTH-1:0]      setpoint,
  input  logic [NUM_CH*PV_WIDTH-1:0]      feedback,
  input  logic [PV_WIDTH-1:0]             iwin,
  output logic                            busy,
  output logic                            out_valid,
  output logic [CH_W-1:0]                 out_ch,
  output logic signed [CONTROL_WIDTH-1:0] control_out,
  output logic signed [PV_WIDTH:0]        error_out,
  output logic                            sat,
  output logic                            overrun
);

  // Error width, multiplier operand widths, product width, and the width of a
  // sum of up to three accumulator terms (which cannot overflow it).
  localparam int EW = PV_WIDTH + 1;
  localparam int MA = GW + 1;
  localparam int MB = PV_WIDTH + 2;
  localparam int PW = MA + MB;
  localparam int SW = ACC_WIDTH + 2;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] C_MAX =
    ACC_WIDTH'({1'b0, {(CONTROL_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0] C_MIN =
    ACC_WIDTH'($signed({1'b1, {(CONTROL_WIDTH-1){1'b0}}}));

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_MP, S_MI, S_MD, S_OUT} state_e;
  typedef enum logic [1:0] {SD_NONE, SD_POS, SD_NEG} satdir_e;

  // Saturating narrowing: the value fits in ACC_WIDTH only when the top three
  // bits of the wide sum agree.
  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [SW-1:0] v);
    if (v[SW-1:ACC_WIDTH-1] == '0 || v[SW-1:ACC_WIDTH-1] == '1) begin
      return v[ACC_WIDTH-1:0];
    end
    return v[SW-1] ? ACC_MIN : ACC_MAX;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                         state_q;
  logic [CH_W-1:0]                ch_q;
  logic signed [EW-1:0]           e_q;
  logic signed [ACC_WIDTH-1:0]    p_q;
  logic signed [ACC_WIDTH-1:0]    integ_q  [NUM_CH];
  logic signed [EW-1:0]           prev_e_q [NUM_CH];
  satdir_e                        satdir_q [NUM_CH];

  logic                           out_valid_q;
  logic [CH_W-1:0]                out_ch_q;
  logic signed [CONTROL_WIDTH-1:0] control_q;
  logic signed [EW-1:0]           error_q;
  logic                           sat_q;
  logic                           overrun_q;

  // ---------------------------------------------------------------------------
  // Per-channel views of the packed input buses
  // ---------------------------------------------------------------------------
  logic [GW-1:0]       kp_a [NUM_CH];
  logic [GW-1:0]       ki_a [NUM_CH];
  logic [GW-1:0]       kd_a [NUM_CH];
  logic [PV_WIDTH-1:0] sp_a [NUM_CH];
  logic [PV_WIDTH-1:0] fb_a [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign kp_a[g] = k_p[g*GW +: GW];
    assign ki_a[g] = k_i[g*GW +: GW];
    assign kd_a[g] = k_d[g*GW +: GW];
    assign sp_a[g] = setpoint[g*PV_WIDTH +: PV_WIDTH];
    assign fb_a[g] = feedback[g*PV_WIDTH +: PV_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic signed [EW-1:0]        e_d;
  logic signed [MA-1:0]        mul_a;
  logic signed [MB-1:0]        mul_b;
  logic signed [MB-1:0]        e_ext;
  logic signed [MB-1:0]        prev_ext;
  logic signed [PW-1:0]        mul_p;
  logic signed [ACC_WIDTH-1:0] prod;

  assign e_d = $signed({1'b0, sp_a[ch_q]}) - $signed({1'b0, fb_a[ch_q]});

  // The single shared multiplier. The gain is zero-extended into a signed
  // operand. The second operand is the error in MP/MI and the error
  // difference in MD.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    e_ext    = MB'(e_q);
    prev_ext = MB'(prev_e_q[ch_q]);
    mul_a    = '0;
    mul_b    = '0;
    unique case (state_q)
      S_MP: begin
        mul_a = $signed({1'b0, kp_a[ch_q]});
        mul_b = e_ext;
      end
      S_MI: begin
        mul_a = $signed({1'b0, ki_a[ch_q]});
        mul_b = e_ext;
      end
      S_MD: begin
        mul_a = $signed({1'b0, kd_a[ch_q]});
        mul_b = e_ext - prev_ext;
      end
      default: ;
    endcase
    mul_p = PW'(mul_a) * PW'(mul_b);
    prod  = ACC_WIDTH'(mul_p);
  end

  // Integrator update and the anti-windup decision (used in MI).
  logic [EW-1:0]               e_abs;
  logic                        e_pos;
  logic                        e_neg;
  logic                        inhibit;
  logic signed [SW-1:0]        integ_sum;
  logic signed [ACC_WIDTH-1:0] integ_d;

  always_comb begin
    e_abs     = e_q[EW-1] ? -e_q : e_q;
    e_pos     = !e_q[EW-1] && (e_q != '0);
    e_neg     = e_q[EW-1];
    // The loop stops integrating outside the window. It also stops while the
    // error would push the output further into the rail it last hit.
    inhibit   = (e_abs > {1'b0, iwin})
             || ((satdir_q[ch_q] == SD_POS) && e_pos)
             || ((satdir_q[ch_q] == SD_NEG) && e_neg);
    integ_sum = SW'(integ_q[ch_q]) + SW'(prod);
    integ_d   = sat_acc(integ_sum);
  end

  // Output sum (used in MD). The result is registered on entry to OUT, so it
  // is presented together with the out_valid strobe. integ_q already holds
  // the value updated in MI.
  logic signed [SW-1:0]            u_sum;
  logic signed [ACC_WIDTH-1:0]     u_acc;
  logic signed [ACC_WIDTH-1:0]     y_acc;
  logic signed [ACC_WIDTH-1:0]     y_cl;
  logic                            clamp_hi;
  logic                            clamp_lo;
  logic signed [CONTROL_WIDTH-1:0] ctrl_d;

  always_comb begin
    u_sum    = SW'(p_q) + SW'(integ_q[ch_q]) + SW'(prod);
    u_acc    = sat_acc(u_sum);
    y_acc    = u_acc >>> PID_FRAC_WIDTH;
    clamp_hi = (y_acc > C_MAX);
    clamp_lo = (y_acc < C_MIN);
    if (clamp_hi) begin
      y_cl = C_MAX;
    end else if (clamp_lo) begin
      y_cl = C_MIN;
    end else begin
      y_cl = y_acc;
    end
    ctrl_d = CONTROL_WIDTH'(y_cl);
  end

  // ---------------------------------------------------------------------------
  // Sequencer and registered state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      e_q         <= '0;
      p_q         <= '0;
      // NOTE: the per-channel arrays are flops, not RAM. They must be reset,
      // because the next sweep reads them as loop state.
      for (int c = 0; c < NUM_CH; c++) begin
        integ_q[c]  <= '0;
        prev_e_q[c] <= '0;
        satdir_q[c] <= SD_NONE;
      end
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      control_q   <= '0;
      error_q     <= '0;
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (!en) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      e_q         <= '0;
      p_q         <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        integ_q[c]  <= '0;
        prev_e_q[c] <= '0;
        satdir_q[c] <= SD_NONE;
      end
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      control_q   <= '0;
      error_q     <= '0;
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      // A strobe that arrives mid-sweep, including in the last OUT cycle, is
      // dropped and only flagged.
      if (sample && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (sample) begin
            ch_q    <= '0;
            state_q <= S_ERR;
          end
        end
        S_ERR: begin
          e_q     <= e_d;
          state_q <= S_MP;
        end
        S_MP: begin
          p_q     <= prod;
          state_q <= S_MI;
        end
        S_MI: begin
          if (!inhibit) begin
            integ_q[ch_q] <= integ_d;
          end
          state_q <= S_MD;
        end
        S_MD: begin
          prev_e_q[ch_q] <= e_q;
          satdir_q[ch_q] <= clamp_hi ? SD_POS : (clamp_lo ? SD_NEG : SD_NONE);
          control_q      <= ctrl_d;
          sat_q          <= clamp_hi || clamp_lo;
          error_q        <= e_q;
          out_ch_q       <= ch_q;
          out_valid_q    <= 1'b1;
          state_q        <= S_OUT;
        end
        S_OUT: begin
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            state_q <= S_IDLE;
          end else begin
            ch_q    <= ch_q + CH_W'(1);
            state_q <= S_ERR;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign out_valid   = out_valid_q;
  assign out_ch      = out_ch_q;
  assign control_out = control_q;
  assign error_out   = error_q;
  assign sat         = sat_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pid_controller_mc.sv
// Testbench for pid_controller_mc (default parameters, two channels).
// Each vector in a table drives one full sweep. Per-channel expected
// results, including the cycle in which they must appear, are pushed to a
// scoreboard queue. A monitor pops and compares them on every out_valid.
// Hand-written sequences cover overrun and the reset-mid-sweep abort.
module tb_pid_controller_mc;

  localparam int NCH = 2;
  localparam int GW  = 16;
  localparam int PVW = 9;
  localparam int CW  = 16;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     en;
  logic                     sample;
  logic [NCH*GW-1:0]        k_p;
  logic [NCH*GW-1:0]        k_i;
  logic [NCH*GW-1:0]        k_d;
  logic [NCH*PVW-1:0]       setpoint;
  logic [NCH*PVW-1:0]       feedback;
  logic [PVW-1:0]           iwin;
  logic                     busy;
  logic                     out_valid;
  logic [0:0]               out_ch;
  logic signed [CW-1:0]     control_out;
  logic signed [PVW:0]      error_out;
  logic                     sat;
  logic                     overrun;

  pid_controller_mc dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .sample      (sample),
    .k_p         (k_p),
    .k_i         (k_i),
    .k_d         (k_d),
    .setpoint    (setpoint),
    .feedback    (feedback),
    .iwin        (iwin),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ch      (out_ch),
    .control_out (control_out),
    .error_out   (error_out),
    .sat         (sat),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int ch;
    int y;
    int e;
    bit s;
    int cyc;
  } exp_t;

  exp_t sb_q[$];

  task automatic push_exp(input int ch, input int y, input int e, input bit s, input int c);
    exp_t x;
    x.ch = ch; x.y = y; x.e = e; x.s = s; x.cyc = c;
    sb_q.push_back(x);
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", out_valid, 0);
      end else begin
        x = sb_q.pop_front();
        check($sformatf("ch%0d_cycle", x.ch),   cyc,         x.cyc);
        check($sformatf("ch%0d_out_ch", x.ch),  out_ch,      x.ch);
        check($sformatf("ch%0d_control", x.ch), control_out, x.y);
        check($sformatf("ch%0d_error", x.ch),   error_out,   x.e);
        check($sformatf("ch%0d_sat", x.ch),     sat,         x.s);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Vector table: one record per sweep
  // ---------------------------------------------------------------------------
  typedef struct {
    bit             clr;  // pulse en=0 before this sweep
    logic [GW-1:0]  kp0, ki0, kd0, kp1, ki1, kd1;
    logic [PVW-1:0] sp0, fb0, sp1, fb1, iw;
    int             y0;
    bit             s0;
    int             y1;
    bit             s1;
  } vec_t;

  function automatic vec_t mk(input bit clr,
                              input int kp0, input int ki0, input int kd0,
                              input int sp0, input int fb0,
                              input int kp1, input int ki1, input int kd1,
                              input int sp1, input int fb1, input int iw,
                              input int y0, input bit s0, input int y1, input bit s1);
    vec_t v;
    v.clr = clr;
    v.kp0 = GW'(kp0); v.ki0 = GW'(ki0); v.kd0 = GW'(kd0);
    v.kp1 = GW'(kp1); v.ki1 = GW'(ki1); v.kd1 = GW'(kd1);
    v.sp0 = PVW'(sp0); v.fb0 = PVW'(fb0);
    v.sp1 = PVW'(sp1); v.fb1 = PVW'(fb1);
    v.iw  = PVW'(iw);
    v.y0 = y0; v.s0 = s0; v.y1 = y1; v.s1 = s1;
    return v;
  endfunction

  int exp_y [NCH];
  int exp_e [NCH];
  bit exp_s [NCH];

  task automatic apply(input vec_t v);
    k_p      = {v.kp1, v.kp0};
    k_i      = {v.ki1, v.ki0};
    k_d      = {v.kd1, v.kd0};
    setpoint = {v.sp1, v.sp0};
    feedback = {v.fb1, v.fb0};
    iwin     = v.iw;
    exp_y[0] = v.y0; exp_s[0] = v.s0; exp_e[0] = int'(v.sp0) - int'(v.fb0);
    exp_y[1] = v.y1; exp_s[1] = v.s1; exp_e[1] = int'(v.sp1) - int'(v.fb1);
  endtask

  // All tasks below are entered 1 time unit after a rising edge.
  task automatic do_clear();
    en = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
  endtask

  // Strobe sample in the current cycle t. A second strobe is optionally sent
  // in cycle t+extra. busy is checked at its rising and falling boundaries.
  task automatic do_sweep(input int extra);
    int t;
    t = cyc;
    sample = 1'b1;
    for (int k = 0; k < NCH; k++) push_exp(k, exp_y[k], exp_e[k], exp_s[k], t + 5 + 5*k);
    for (int i = 1; i <= 5*NCH + 1; i++) begin
      @(posedge clk); #1;
      sample = (i == extra);
      if (i == 1)         check("busy_rise", busy, 1);
      if (i == 5*NCH)     check("busy_last_out", busy, 1);
      if (i == 5*NCH + 1) check("busy_fall", busy, 0);
    end
    check("sb_drained", sb_q.size(), 0);
  endtask

  vec_t vecs [15];
  vec_t rv;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t0;
    //                clr kp0     ki0     kd0     sp0 fb0  kp1     ki1 kd1     sp1 fb1  iwin  y0     s0 y1  s1
    vecs[0]  = mk(1, 'h0100, 0,      0,      200, 100, 0,      0,  0,      50,  60,  0,   100,   0, 0,   0);
    // Integration window 5 (ch0). Ch1 at gain 0.5 with e=-7 checks the floor shift.
    vecs[1]  = mk(1, 0,      'h0080, 0,      104, 100, 'h0080, 0,  0,      0,   7,   5,   2,     0, -4,  0);
    vecs[2]  = mk(0, 0,      'h0080, 0,      104, 100, 'h0080, 0,  0,      0,   7,   5,   4,     0, -4,  0);
    vecs[3]  = mk(0, 0,      'h0080, 0,      104, 100, 'h0080, 0,  0,      0,   7,   5,   6,     0, -4,  0);
    vecs[4]  = mk(0, 0,      'h0080, 0,      110, 100, 'h0080, 0,  0,      0,   7,   5,   6,     0, -4,  0);
    vecs[5]  = mk(0, 0,      'h0080, 0,      105, 100, 'h0080, 0,  0,      0,   7,   5,   8,     0, -4,  0);
    vecs[6]  = mk(0, 0,      'h0080, 0,      94,  100, 'h0080, 0,  0,      0,   7,   5,   8,     0, -4,  0);
    // Output clamping at both rails.
    vecs[7]  = mk(1, 'hFFFF, 0,      0,      255, 0,   'h0100, 0,  0,      511, 0,   0,   32767, 1, 511, 0);
    vecs[8]  = mk(0, 'h8000, 0,      0,      0,   511, 'h0100, 0,  0,      511, 0,   0,  -32768, 1, 511, 0);
    // Directional anti-windup on ch0, derivative gain 1.0 on ch1.
    vecs[9]  = mk(1, 'h8000, 'h0100, 0,      300, 0,   0,      0,  'h0100, 20,  0,   511, 32767, 1, 20,  0);
    vecs[10] = mk(0, 'h8000, 'h0100, 0,      300, 0,   0,      0,  'h0100, 20,  0,   511, 32767, 1, 0,   0);
    vecs[11] = mk(0, 'h8000, 'h0100, 0,      299, 300, 0,      0,  'h0100, 20,  0,   511, 171,   0, 0,   0);
    // Derivative gain 2.0 on ch0.
    vecs[12] = mk(1, 0,      0,      'h0200, 100, 100, 0,      0,  0,      0,   0,   0,   0,     0, 0,   0);
    vecs[13] = mk(0, 0,      0,      'h0200, 110, 100, 0,      0,  0,      0,   0,   0,   20,    0, 0,   0);
    vecs[14] = mk(0, 0,      0,      'h0200, 110, 100, 0,      0,  0,      0,   0,   0,   0,     0, 0,   0);

    reset_n = 1'b1; en = 1'b1; sample = 1'b0;
    k_p = '0; k_i = '0; k_d = '0; setpoint = '0; feedback = '0; iwin = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_control", control_out, 0);
    check("rst_error", error_out, 0);
    check("rst_sat", sat, 0);
    check("rst_overrun", overrun, 0);
    check("rst_out_ch", out_ch, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].clr) do_clear();
      apply(vecs[i]);
      do_sweep(0);
    end

    // Overrun: a strobe mid-sweep, then a strobe in the last OUT cycle (dropped),
    // then an immediate new strobe in the first idle cycle (accepted).
    do_clear();
    apply(vecs[0]);
    check("overrun_idle", overrun, 0);
    do_sweep(3);
    check("overrun_mid_sweep", overrun, 1);
    do_clear();
    check("overrun_cleared_by_en", overrun, 0);
    do_sweep(5*NCH);
    check("overrun_last_out", overrun, 1);
    do_sweep(0);
    check("overrun_sticky", overrun, 1);

    // Reset during channel 1: outputs clear at once and no further results appear.
    apply(vecs[0]);
    t0 = cyc;
    sample = 1'b1;
    push_exp(0, 100, 100, 1'b0, t0 + 5);
    @(posedge clk); #1;
    sample = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_control", control_out, 0);
    check("abort_error", error_out, 0);
    check("abort_sat", sat, 0);
    check("abort_overrun", overrun, 0);
    check("abort_out_ch", out_ch, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("abort_no_pending", sb_q.size(), 0);
    check("abort_idle", busy, 0);

    // The derivative after the abort uses prev_e = 0: gain 1.0 with e=5 gives 5.
    rv = mk(0, 0, 0, 'h0100, 105, 100, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    apply(rv);
    do_sweep(0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pid_controller_mc.md
# pid_controller_mc

Multi-channel, time-multiplexed PID controller: the parametrised successor to the single-loop PID block. One shared multiplier serves `NUM_CH` independent control loops in a sequential sweep started by a sample strobe. Per-channel state is the integrator, previous error and saturation direction. New behaviour:

- integration window plus directional anti-windup,
- clamped output with a saturation flag,
- per-channel output valid strobe,
- overrun detection.

It sits between the sensor/setpoint registers and the motor drive stage.

## Interface
Parameters:
- `NUM_CH`, 2: number of control loops (1..8).
- `PID_INT_WIDTH`, 8: gain integer bits (unsigned).
- `PID_FRAC_WIDTH`, 8: gain fraction bits.
- `PV_WIDTH`, 9: setpoint/feedback width (unsigned).
- `CONTROL_WIDTH`, 16: signed output width.
- `ACC_WIDTH`, 32: signed integrator/sum width, fraction `PID_FRAC_WIDTH` bits. Must be ≥ `PID_INT_WIDTH+PID_FRAC_WIDTH+PV_WIDTH+4`.

Ports:
- `clk` in 1: the single clock; all logic on its rising edge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `en` in 1: 0 = synchronous clear of all loop state and outputs.
- `sample` in 1: one-cycle strobe that starts a sweep.
- `k_p`, `k_i`, `k_d` in `NUM_CH*(PID_INT_WIDTH+PID_FRAC_WIDTH)` each: unsigned Q(INT.FRAC) gains; channel k occupies slice k.
- `setpoint`, `feedback` in `NUM_CH*PV_WIDTH` each: unsigned, sliced per channel.
- `iwin` in `PV_WIDTH`: integration window; integrate only when |e| ≤ `iwin`.
- `busy` out 1: sweep in progress.
- `out_valid` out 1: one-cycle strobe; `out_ch`, `control_out`, `error_out` and `sat` are valid in that cycle.
- `out_ch` out `max(1,$clog2(NUM_CH))`: channel index of the current result.
- `control_out` out signed `CONTROL_WIDTH`: clamped control value, integer part.
- `error_out` out signed `PV_WIDTH+1`: the error used for this result.
- `sat` out 1: `control_out` was clamped.
- `overrun` out 1: sticky; `sample` arrived while `busy`. Cleared by `en`=0 or reset.

## Operation
- FSM: IDLE → ERR → MP → MI → MD → OUT → ERR (next channel) … After OUT of channel `NUM_CH-1`, return to IDLE.
- IDLE:
  - `sample`=1 and `en`=1 → ERR with channel counter ch=0.
  - `sample` while not in IDLE is ignored and sets `overrun`.
- ERR: e = {0,setpoint[ch]} − {0,feedback[ch]}, signed `PV_WIDTH+1`, registered.
- MP: p = k_p[ch]·e, sign-extended to `ACC_WIDTH`.
- MI: integrator update.
  - inhibit = (|e| > `iwin`) OR (satdir[ch]=+1 AND e>0) OR (satdir[ch]=−1 AND e<0).
  - If not inhibited: integ[ch] ← integ[ch] + k_i[ch]·e, saturated to the `ACC_WIDTH` signed range. Otherwise integ[ch] is held (not cleared).
- MD: d = k_d[ch]·(e − prev_e[ch]); prev_e[ch] ← e.
- OUT:
  - u = p + integ[ch] (updated value) + d, saturating in `ACC_WIDTH`.
  - y = u >>> `PID_FRAC_WIDTH` (arithmetic, floor).
  - Clamp y to [−2^(CW−1), 2^(CW−1)−1]. `sat`=1 iff clamped.
  - satdir[ch] ← +1 / −1 / 0 for high clamp / low clamp / none.
  - Register `control_out`, `error_out`, `out_ch`; pulse `out_valid`; then ch+1.
- Only one multiply per cycle: a shared (INT+FRAC+1)×(PV+2) signed multiplier.
- Input sampling: setpoint/feedback are captured in ERR. Gains are read in MP/MI/MD and must be stable while `busy`.
- `en`=0, any state:
  - FSM → IDLE.
  - integ, prev_e and satdir of every channel → 0.
  - Output registers → 0; `overrun` → 0.
- Reset (`reset_n`=0): identical clear, asynchronously. All outputs are 0, including `busy`, `out_valid` and `sat`.

## Timing
- `sample` high in cycle t (IDLE): channel k's `out_valid` occurs in cycle t+5+5k.
- `busy`: high t+1 through t+5·`NUM_CH` inclusive; low in cycle t+5·`NUM_CH`+1.
- A new `sample` is accepted from the first cycle `busy`=0. A `sample` in the last OUT cycle sets `overrun` and is dropped.
- Output registers hold their values between `out_valid` strobes.
- Reset or `en`=0 mid-sweep:
  - the sweep is aborted;
  - no further `out_valid`;
  - the next sample's derivative uses prev_e=0.

## Test plan
- NUM_CH=2, k_p[0]=0x0100 (1.0), k_i=k_d=0, sp=200, fb=100, `sample` at t → `out_valid` at t+5 with ch=0, control_out=100, error_out=100, sat=0. Channel 1 (all gains 0) gives control_out=0 at t+10; `busy` falls at t+11.
- k_i[0]=0x0080 (0.5), iwin=5, e=4, three sweeps → control_out 2, 4, 6. Change e to 10 → control_out stays 6 (integrator held).
- k_p=0xFFFF, e=255 → control_out=32767, sat=1. Then k_p=0x8000, sp=0, fb=511 → control_out=−32768, sat=1.
- Anti-windup: k_i=0x0100, iwin=511, k_p=0x8000, e=+300 → sat=1 and satdir=+1. Next sweep with same e → integrator unchanged; with e=−1 → integrator decrements by 1.
- k_d=0x0200, e=0 then 10 then 10 → control_out 0, 20, 0.
- `sample` while `busy` → `overrun`=1, sweep timing unaffected. Pulse `reset_n` low during channel 1 → all outputs 0 immediately; subsequent sweep with k_d=0x0100, e=5 → control_out=5.
